// File: rtl/route_pkg.sv
// Shared definitions for the select-router protocol (transmit router and route_unmux).
// Holds the word class enum, the select-code boundaries, and the class decode
// function, so both ends of the routed bus apply identical rules.
package route_pkg;

  // Word class carried with each recovered triple. CLS_ERROR never reaches an output.
  typedef enum logic [1:0] {
    CLS_DIRECT = 2'd0,
    CLS_SWAP   = 2'd1,
    CLS_C_ONLY = 2'd2,
    CLS_ERROR  = 2'd3
  } route_cls_e;

  // Select-code boundaries used by the router.
  localparam int unsigned SEL_DIRECT   = 0;
  localparam int unsigned SEL_SWAP_MAX = 5;
  localparam int unsigned SEL_C_LO     = 6;
  localparam int unsigned SEL_C_HI     = 7;

  // Classify a routed word from its select code s and the router's echo w.
  // Callers zero-extend their WIDTH-bit fields to 32 bits, which keeps the
  // comparison unsigned at the original width.
  // DIRECT and SWAP words are only trusted when the echo matches the select.
  // C_ONLY words carry no meaningful echo, so w is ignored for them.
  function automatic route_cls_e route_decode(input logic [31:0] s,
                                              input logic [31:0] w);
    route_cls_e cls;
    cls = CLS_ERROR;
    if (s == SEL_DIRECT) begin
      cls = (w == s) ? CLS_DIRECT : CLS_ERROR;
    end else if (s <= SEL_SWAP_MAX) begin
      cls = (w == s) ? CLS_SWAP : CLS_ERROR;
    end else if ((s >= SEL_C_LO) && (s <= SEL_C_HI)) begin
      cls = CLS_C_ONLY;
    end else begin
      cls = CLS_ERROR;
    end
    return cls;
  endfunction

endpackage

// File: rtl/route_class_decode.sv
// Combinational class decode for one routed word.
// Ports: s_i (select code), w_i (router echo of s) in; cls_o (word class) out.
// Zero latency, no state. WIDTH must be at least 3 so that codes 6 and 7 exist.
module route_class_decode
  import route_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] w_i,
  output route_cls_e       cls_o
);

  logic [31:0] s_ext;
  logic [31:0] w_ext;

  // Zero-extend so the shared 32-bit decode compares unsigned at WIDTH bits.
  assign s_ext = 32'(s_i);
  assign w_ext = 32'(w_i);

  assign cls_o = route_decode(s_ext, w_ext);

endmodule

// File: rtl/route_unmux.sv
// Receive-side unmux: recovers (a, b, c) from routed (v, y, t, w) under select s.
// Ports: clk/rst_n; in_valid/in_ready + in_s/in_v/in_y/in_t/in_w; out_valid/out_ready
// + out_a/out_b/out_c/out_cls; err_pulse/err_count for rejected words.
// Latency 1 (accept edge loads the output stage); in_ready drops only when the stage
// is full and the consumer is not draining it this cycle, so throughput is one per cycle.
module route_unmux
  import route_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // Routed word in
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_v,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_w,
  // Recovered triple out
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [1:0]       out_cls,
  // Malformed-word reporting
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Output stage
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  route_cls_e       out_cls_q, out_cls_d;

  // Last successfully recovered a and b, reused by C_ONLY words
  logic [WIDTH-1:0] hold_a_q, hold_a_d;
  logic [WIDTH-1:0] hold_b_q, hold_b_d;

  // Error reporting
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  route_cls_e       in_cls;
  logic             accept;
  logic             load;
  logic             reject;
  logic [WIDTH-1:0] rec_a;
  logic [WIDTH-1:0] rec_b;
  logic [WIDTH-1:0] rec_c;

  route_class_decode #(
    .WIDTH(WIDTH)
  ) u_class_decode (
    .s_i  (in_s),
    .w_i  (in_w),
    .cls_o(in_cls)
  );

  // in_ready is computed in the output process below; accept is gated by it,
  // so undefined input fields while in_valid=0 never reach any register.
  assign accept = in_valid && in_ready;
  assign load   = accept && (in_cls != CLS_ERROR);
  assign reject = accept && (in_cls == CLS_ERROR);

  // Undo the router's mapping for the decoded class.
  always_comb begin
    rec_a = in_v;
    rec_b = in_y;
    rec_c = in_t;
    case (in_cls)
      CLS_DIRECT: begin
        rec_a = in_v;
        rec_b = in_y;
        rec_c = in_t;
      end
      CLS_SWAP: begin
        rec_a = in_t;
        rec_b = in_y;
        rec_c = in_v;
      end
      CLS_C_ONLY: begin
        rec_a = hold_a_q;
        rec_b = hold_b_q;
        rec_c = in_v;
      end
      default: begin
        rec_a = in_v;
        rec_b = in_y;
        rec_c = in_t;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // Draining: refill only if a good word arrives in the same cycle.
        // An error word accepted here still leaves the stage empty.
        if (out_ready) begin
          state_d = load ? ST_FULL : ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // out_valid is masked by rst_n so no output handshake can complete in a
  // reset cycle, even though the state register only clears on the edge.
  always_comb begin
    in_ready  = rst_n && ((state_q == ST_EMPTY) || out_ready);
    out_valid = rst_n && (state_q == ST_FULL);
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    out_cls_d   = out_cls_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    err_pulse_d = reject;
    err_count_d = err_count_q;

    // A good word can only be accepted when the stage is empty or being
    // drained, so overwriting here never disturbs a stalled triple.
    if (load) begin
      out_a_d   = rec_a;
      out_b_d   = rec_b;
      out_c_d   = rec_c;
      out_cls_d = in_cls;
      hold_a_d  = rec_a;
      hold_b_d  = rec_b;
    end

    if (reject && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_cls_q   <= CLS_DIRECT;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      out_cls_q   <= out_cls_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign out_cls   = out_cls_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_route_unmux.sv
// Directed bench for route_unmux: two instances share all inputs, one with the
// default 8-bit error counter and one with a 2-bit counter to reach saturation.
// Expected values are hand-computed constants.
module tb_route_unmux;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_s, in_v, in_y, in_t, in_w;
  logic             out_ready;

  logic             in_ready, out_valid, err_pulse;
  logic [WIDTH-1:0] out_a, out_b, out_c;
  logic [1:0]       out_cls;
  logic [7:0]       err_count;

  logic             s_in_ready, s_out_valid, s_err_pulse;
  logic [WIDTH-1:0] s_out_a, s_out_b, s_out_c;
  logic [1:0]       s_out_cls;
  logic [1:0]       s_err_count;

  int n_checks;
  int n_fail;
  int pulses;

  route_unmux #(.WIDTH(WIDTH), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_v(in_v), .in_y(in_y), .in_t(in_t), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_cls(out_cls),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  route_unmux #(.WIDTH(WIDTH), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_s(in_s), .in_v(in_v), .in_y(in_y), .in_t(in_t), .in_w(in_w),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_a(s_out_a), .out_b(s_out_b), .out_c(s_out_c), .out_cls(s_out_cls),
    .err_pulse(s_err_pulse), .err_count(s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one edge, then drop in_valid.
  task automatic send(input logic [3:0] s, input logic [3:0] w, input logic [3:0] v,
                      input logic [3:0] y, input logic [3:0] t);
    in_valid = 1'b1;
    in_s = s; in_w = w; in_v = v; in_y = y; in_t = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_triple(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [1:0] cls);
    chk({tag, ".valid"}, 32'(out_valid), 32'(1'b1));
    chk({tag, ".a"},     32'(out_a),     32'(a));
    chk({tag, ".b"},     32'(out_b),     32'(b));
    chk({tag, ".c"},     32'(out_c),     32'(c));
    chk({tag, ".cls"},   32'(out_cls),   32'(cls));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pulses   = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_s = '0; in_v = '0; in_y = '0; in_t = '0; in_w = '0;

    // Reset state
    tick(); tick();
    chk("rst.out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst.out_a",     32'(out_a),     32'(4'h0));
    chk("rst.out_cls",   32'(out_cls),   32'(2'd0));
    chk("rst.err_pulse", 32'(err_pulse), 32'(1'b0));
    chk("rst.err_count", 32'(err_count), 32'(8'd0));
    chk("rst.in_ready",  32'(in_ready),  32'(1'b0));
    rst_n = 1'b1;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'(1'b1));

    // DIRECT, SWAP, then C_ONLY reusing held a/b
    out_ready = 1'b1;
    send(4'd0, 4'd0, 4'd1, 4'd2, 4'd3);
    chk_triple("direct", 4'd1, 4'd2, 4'd3, 2'd0);
    send(4'd5, 4'd5, 4'd9, 4'd4, 4'd7);
    chk_triple("swap", 4'd7, 4'd4, 4'd9, 2'd1);
    send(4'd6, 4'd0, 4'hE, 4'd0, 4'd0);
    chk_triple("conly", 4'd7, 4'd4, 4'hE, 2'd2);
    tick();
    chk("drain.out_valid", 32'(out_valid), 32'(1'b0));

    // Error words: echo mismatch, then out-of-range select
    send(4'd3, 4'd2, 4'd1, 4'd1, 4'd1);
    chk("err1.out_valid", 32'(out_valid), 32'(1'b0));
    chk("err1.pulse",     32'(err_pulse), 32'(1'b1));
    chk("err1.count",     32'(err_count), 32'(8'd1));
    send(4'd9, 4'd9, 4'd1, 4'd1, 4'd1);
    chk("err2.out_valid", 32'(out_valid), 32'(1'b0));
    chk("err2.pulse",     32'(err_pulse), 32'(1'b1));
    chk("err2.count",     32'(err_count), 32'(8'd2));
    tick();
    chk("err_idle.pulse", 32'(err_pulse), 32'(1'b0));
    chk("err_idle.count", 32'(err_count), 32'(8'd2));
    chk("err_idle.sat_count", 32'(s_err_count), 32'(2'd2));
    // Hold registers untouched by errors
    send(4'd7, 4'd0, 4'd5, 4'd0, 4'd0);
    chk_triple("hold", 4'd7, 4'd4, 4'd5, 2'd2);

    // Backpressure: stage full, consumer stalled, new word waiting
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_s = 4'd0; in_w = 4'd0; in_v = 4'hA; in_y = 4'hB; in_t = 4'hC;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", 32'(in_ready), 32'(1'b0));
      chk_triple("bp", 4'd7, 4'd4, 4'd5, 2'd2);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 32'(1'b1));
    tick();
    in_valid = 1'b0;
    chk_triple("bp_reload", 4'hA, 4'hB, 4'hC, 2'd0);
    tick();
    chk("bp_drain.out_valid", 32'(out_valid), 32'(1'b0));

    // Five back-to-back error words
    for (int i = 0; i < 5; i++) begin
      send(4'hF, 4'hF, 4'd0, 4'd0, 4'd0);
      if (s_err_pulse === 1'b1) pulses++;
    end
    chk("sat.pulses",     32'(pulses),      32'd5);
    chk("sat.sat_count",  32'(s_err_count), 32'(2'd3));
    chk("sat.count",      32'(err_count),   32'(8'd7));
    chk("sat.out_valid",  32'(out_valid),   32'(1'b0));
    tick();
    chk("sat_idle.pulse", 32'(s_err_pulse), 32'(1'b0));

    // Reset while full and stalled
    out_ready = 1'b0;
    send(4'd0, 4'd0, 4'd1, 4'd1, 4'd1);
    chk("mid.out_valid_before", 32'(out_valid), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid.out_valid_in_rst", 32'(out_valid), 32'(1'b0));
    chk("mid.in_ready_in_rst",  32'(in_ready),  32'(1'b0));
    tick();
    rst_n = 1'b1;
    chk("mid.out_valid", 32'(out_valid),   32'(1'b0));
    chk("mid.out_a",     32'(out_a),       32'(4'h0));
    chk("mid.out_c",     32'(out_c),       32'(4'h0));
    chk("mid.err_count", 32'(err_count),   32'(8'd0));
    chk("mid.sat_count", 32'(s_err_count), 32'(2'd0));
    out_ready = 1'b1;
    send(4'd7, 4'd3, 4'd6, 4'd9, 4'd9);
    chk_triple("post_rst_conly", 4'd0, 4'd0, 4'd6, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/route_unmux.md
Name: route_unmux

Overview:
- Receive-side counterpart of the 4-bit select router. The router drives v, y, t, w from a, b, c under select s; this block takes those routed words plus s and recovers the original a, b, c.
- Registered, valid/ready handshaked, one-entry output stage with malformed-word detection and a saturating error counter.
- Sits at the far end of the routed bus, feeding a downstream consumer that applies backpressure.

Parameters:
- WIDTH, 4, data and select width (must be ≥3 so that 6 and 7 are representable)
- ERR_W, 8, error counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  routed word present
- in_ready  out  1  block accepts the word this cycle
- in_s  in  WIDTH  select code used by the router
- in_v  in  WIDTH  routed word v
- in_y  in  WIDTH  routed word y
- in_t  in  WIDTH  routed word t
- in_w  in  WIDTH  routed word w (router echo of s)
- out_valid  out  1  recovered triple available
- out_ready  in  1  consumer takes the triple
- out_a  out  WIDTH  recovered a
- out_b  out  WIDTH  recovered b
- out_c  out  WIDTH  recovered c
- out_cls  out  2  class of the word: 0 DIRECT, 1 SWAP, 2 C_ONLY
- err_pulse  out  1  one-cycle pulse per rejected word
- err_count  out  ERR_W  saturating count of rejected words

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_a/b/c=0, out_cls=0, err_pulse=0, err_count=0.
  - Hold registers for a and b are cleared to 0. FSM goes to EMPTY.
  - in_ready=0 while rst_n is low.
- Handshake:
  - Transfer occurs when valid && ready at a clk edge.
  - in_ready = rst_n && (state==EMPTY || out_ready). This is combinational from out_ready, so a triple can be drained and a new one loaded in the same cycle (full throughput).
  - out_valid, out_a/b/c and out_cls must stay stable while out_valid && !out_ready.
- Class decode of an accepted word (compare at WIDTH bits, unsigned):
  - s==0 → DIRECT: a=v, b=y, c=t.
  - 1≤s≤5 → SWAP: a=t, b=y, c=v.
  - For DIRECT and SWAP, in_w must equal in_s; a mismatch makes the word an ERROR.
  - s==6 or s==7 → C_ONLY: c=v; a and b are taken from the hold registers (last successfully recovered a and b); in_w is ignored.
  - Any other s → ERROR.
- ERROR word:
  - Consumed (in_ready behaves as normal) and never reaches the output.
  - err_pulse=1 in the following cycle only. err_count increments and saturates at all-ones.
  - The output stage and the hold registers are unchanged.
- Non-error accepted word:
  - Output registers load on the accept edge, so out_valid rises 1 cycle after the accept (latency 1).
  - Hold registers update with the new a and b (for C_ONLY they are rewritten with their own value).
- FSM (2 states):
  - EMPTY: accept a non-error word → FULL; accept an error word → EMPTY.
  - FULL: out_ready && no accept → EMPTY; out_ready && non-error accept → FULL with new data; out_ready && error accept → EMPTY; !out_ready → FULL (in_ready=0).
- in_valid with no accept has no effect. Input X values are not propagated when in_valid=0.
- Reset mid-transfer: a pending triple is discarded; no output handshake completes in the reset cycle.
- err_count at saturation: further errors still pulse err_pulse but the count holds.

Decomposition:
- Shared package route_pkg holds:
  - class enum (DIRECT=0, SWAP=1, C_ONLY=2, ERROR=3)
  - select constants SEL_DIRECT=0, SEL_SWAP_MAX=5, SEL_C_LO=6, SEL_C_HI=7
  - the decode function, so the transmit-side router and this block share it
- One natural sub-module, route_class_decode: combinational; inputs s and w; outputs class. This isolates the protocol rules from the handshake and FSM logic.

Test Plan:
- Reset, then s=0, w=0, v=1, y=2, t=3, out_ready=1 → the next cycle shows out_valid=1, a=1, b=2, c=3, cls=0.
- s=5, w=5, v=9, y=4, t=7 → a=7, b=4, c=9, cls=1. Then s=6, v=0xE → a=7, b=4, c=0xE, cls=2.
- s=3, w=2 (mismatch) and s=9 → no out_valid, err_pulse once per word, err_count=2, hold registers unchanged.
- Backpressure: out_ready=0 while FULL → in_ready=0 and outputs stable for 5 cycles. Raise out_ready with a new word presented → drain and load in the same cycle, no bubble.
- Saturation with ERR_W=2: 5 error words → err_count=3, err_pulse seen 5 times.
- Assert rst_n=0 while FULL with out_ready=0 → next cycle out_valid=0, outputs 0, err_count=0. A following s=7 yields a=0, b=0.
